// File: rtl/power_spec_packer.sv
// power_spec_packer
//   Keeps the lower KeepBins bins of each power-spectrum frame, pairs each
//   even bin with the odd bin that follows it, buffers the pairs in a FIFO and
//   drains one pair per output beat onto the four 16-bit user-logic lanes.
//
// Optional feature (compile-time macro PACKER_HEADER_EN):
//   When defined, one header beat (A55A / frame number / KeepBins / 0000) is
//   issued ahead of the first data beat of every frame.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   spec_i                32-bit unsigned power-spectrum word
//   spec_index_i          bin index of spec_i
//   spec_valid_i          spec_i / spec_index_i valid this cycle
//   ready_i               downstream pull enable, one beat per cycle while high
//   y0_o / y0z_o          even bin [31:16] / [15:0]
//   y1_o / y1z_o          odd bin  [31:16] / [15:0]
//   data_valid_o          one-cycle strobe per output beat
//   frame_start_o         marks the first beat of a frame
//   frame_cnt_o           frames started (bin 0 accepted), wraps
//   overflow_o            sticky: a pair was dropped on a full FIFO
//   seq_err_o             sticky: an odd bin arrived with no pending even bin
//
// Handshake: the input side has no backpressure; a word is taken on every
// rising edge where spec_valid_i=1. The output side pops one entry on every
// rising edge where ready_i=1 and the FIFO holds data; the beat appears on the
// lanes one cycle later together with data_valid_o.
module power_spec_packer #(
    parameter int NofBits   = 16,
    parameter int NofBins   = 1024,
    parameter int KeepBins  = 512,
    parameter int FifoDepth = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [31:0]                spec_i,
    input  logic [$clog2(NofBins)-1:0] spec_index_i,
    input  logic                       spec_valid_i,
    input  logic                       ready_i,
    output logic [NofBits-1:0]         y0_o,
    output logic [NofBits-1:0]         y0z_o,
    output logic [NofBits-1:0]         y1_o,
    output logic [NofBits-1:0]         y1z_o,
    output logic                       data_valid_o,
    output logic                       frame_start_o,
    output logic [15:0]                frame_cnt_o,
    output logic                       overflow_o,
    output logic                       seq_err_o
);

    localparam int AW = $clog2(FifoDepth);

`ifdef PACKER_HEADER_EN
    // Each entry also carries the frame number captured at bin 0, so the
    // header stays correct even when several frames sit in the FIFO.
    localparam int EW = 81;
    localparam logic [15:0] HDR_MAGIC = 16'hA55A;
    localparam logic [15:0] KEEP_W    = 16'(KeepBins);
`else
    localparam int EW = 65;
`endif

    // ---------------- input filter and pairing ----------------
    logic [31:0] idx_ext;
    logic        in_keep;
    logic        is_odd;
    logic        is_zero;
    logic        wr_en;
    logic [EW-1:0] wr_data;

    logic        pend_valid;
    logic        pend_first;
    logic [31:0] pend_even;

    assign idx_ext = 32'(spec_index_i);
    assign in_keep = spec_valid_i && (idx_ext < 32'(KeepBins));
    assign is_odd  = spec_index_i[0];
    assign is_zero = (spec_index_i == '0);
    assign wr_en   = in_keep && is_odd && pend_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_valid  <= 1'b0;
            pend_first  <= 1'b0;
            pend_even   <= '0;
            frame_cnt_o <= '0;
            seq_err_o   <= 1'b0;
        end else if (in_keep) begin
            if (!is_odd) begin
                // A new even bin silently replaces any unpaired one.
                pend_valid <= 1'b1;
                pend_first <= is_zero;
                pend_even  <= spec_i;
                if (is_zero) frame_cnt_o <= frame_cnt_o + 16'd1;
            end else if (pend_valid) begin
                pend_valid <= 1'b0;
            end else begin
                seq_err_o <= 1'b1;
            end
        end
    end

`ifdef PACKER_HEADER_EN
    logic [15:0] pend_fnum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_fnum <= '0;
        end else if (in_keep && !is_odd && is_zero) begin
            pend_fnum <= frame_cnt_o;  // value before this frame's increment
        end
    end

    assign wr_data = {pend_fnum, pend_first, pend_even, spec_i};
`else
    assign wr_data = {pend_first, pend_even, spec_i};
`endif

    // ---------------- pair FIFO ----------------
    logic [EW-1:0] mem [FifoDepth];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic [EW-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    // A simultaneous pop frees the slot, so a write on a full FIFO still fits.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full && !pop) overflow_o <= 1'b1;
        end
    end

    // ---------------- drain ----------------
`ifdef PACKER_HEADER_EN
    typedef enum logic {ST_HDR, ST_DATA} drain_state_t;
    // ST_HDR: a first-tagged head still needs its header beat.
    // ST_DATA: header issued, the next ready cycle pops the bin 0/1 pair.
    drain_state_t drain_state;
    logic         hdr_go;

    assign hdr_go = ready_i && !empty && head[64] && (drain_state == ST_HDR);
    assign pop    = ready_i && !empty && !hdr_go;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drain_state   <= ST_HDR;
            y0_o          <= '0;
            y0z_o         <= '0;
            y1_o          <= '0;
            y1z_o         <= '0;
            data_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            data_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            if (hdr_go) begin
                y0_o          <= HDR_MAGIC;
                y0z_o         <= head[80:65];
                y1_o          <= KEEP_W;
                y1z_o         <= 16'h0000;
                data_valid_o  <= 1'b1;
                frame_start_o <= 1'b1;
                drain_state   <= ST_DATA;
            end else if (pop) begin
                y0_o          <= head[63:48];
                y0z_o         <= head[47:32];
                y1_o          <= head[31:16];
                y1z_o         <= head[15:0];
                data_valid_o  <= 1'b1;
                drain_state   <= ST_HDR;
            end
        end
    end
`else
    assign pop = ready_i && !empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y0_o          <= '0;
            y0z_o         <= '0;
            y1_o          <= '0;
            y1z_o         <= '0;
            data_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (pop) begin
            y0_o          <= head[63:48];
            y0z_o         <= head[47:32];
            y1_o          <= head[31:16];
            y1z_o         <= head[15:0];
            data_valid_o  <= 1'b1;
            frame_start_o <= head[64];
        end else begin
            data_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/power_spec_packer.md
Name: power_spec_packer

Overview:
Consumes the per-bin 32-bit power-spectrum stream produced by the FFT/power-spectrum stage and keeps the lower KeepBins bins of each frame. It pairs consecutive bins and buffers the pairs. It drains them onto the four 16-bit user-logic sample lanes (y0/y0z/y1/y1z) with a data-valid strobe, paced by a downstream pull enable. This is the read side of the spectrum stream, sitting between the spectrum calculator and the user-logic signal outputs.

Parameters:
NofBits, 16, width of each output lane; must be 16 (a spectrum word is split into two lanes).
NofBins, 1024, FFT length; spec_index_i width is log2(NofBins).
KeepBins, 512, bins kept per frame (indices 0..KeepBins-1); even; 2 <= KeepBins <= NofBins.
FifoDepth, 256, pair-FIFO depth in entries; power of 2.

Ports:
clk_i  in  1  sample clock; all logic on rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
spec_i  in  32  power-spectrum word (unsigned).
spec_index_i  in  10  bin index of spec_i (log2(NofBins) bits).
spec_valid_i  in  1  spec_i/spec_index_i valid this cycle.
ready_i  in  1  downstream pull enable; one beat may issue per cycle while high.
y0_o  out  16  even bin [31:16].
y0z_o  out  16  even bin [15:0].
y1_o  out  16  odd bin [31:16].
y1z_o  out  16  odd bin [15:0].
data_valid_o  out  1  one-cycle strobe per output beat.
frame_start_o  out  1  high with data_valid_o on the first beat of a frame.
frame_cnt_o  out  16  frames started (bin 0 accepted); wraps at 16'hFFFF->0.
overflow_o  out  1  sticky: a pair was dropped because the FIFO was full.
seq_err_o  out  1  sticky: an odd bin was dropped with no pending even bin.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; pairing register invalid; header state (if built) idle. Reset mid-frame discards all buffered data. The next frame starts only at index 0.
- Input filter: words with spec_valid_i=1 and spec_index_i >= KeepBins are ignored. These words have no flag effect.
- Pairing:
  - Even index accepted: stored in the pair register, which is marked pending. It overwrites any pending even bin silently.
  - Index 0 accepted: frame_cnt_o increments, and the pending pair is tagged first-of-frame.
  - Odd index accepted with pending even bin: {first_tag, even, odd} is written to the FIFO on the same edge, and pending is cleared.
  - Odd index accepted with no pending even bin: the word is dropped and seq_err_o is set.
- FIFO: 65 bits wide, FifoDepth entries.
  - Write while full with no read in the same cycle: the pair is dropped and overflow_o is set.
  - Write while full with a read in the same cycle: the write is accepted.
  - Read while empty: no action.
- Drain: in cycle N, with ready_i=1 and the FIFO non-empty, the head is popped. At N+1, y*_o carry the pair and data_valid_o=1 for one cycle. frame_start_o equals the entry's first tag.
- y*_o hold their last value when data_valid_o=0.
- Latency: odd bin accepted at edge E → earliest data_valid_o in the cycle after E+1 (2 clocks), given ready_i held high.
- Throughput: input at most one bin per cycle; output up to two bins per cycle. The FIFO absorbs ready_i gaps.
- Sticky flags clear only on reset.

Optional Feature:
PACKER_HEADER_EN
- Defined: before the first data beat of each frame, one header beat is issued on the first cycle the head entry is first-tagged and ready_i=1:
  - y0_o=16'hA55A, y0z_o=frame number (frame_cnt_o value captured when bin 0 was accepted), y1_o=KeepBins, y1z_o=16'h0000.
  - data_valid_o=1 and frame_start_o=1 on the header beat.
  - The header pops nothing. The data beat for bins 0/1 follows on the next ready cycle with frame_start_o=0.
  - A 2-state drain FSM is used: HDR, DATA.
- Undefined: no header, no FSM; behaviour as in Behaviour.

Test Plan:
- Reset values: hold rst_n_i=0 with random inputs → all outputs 0. Release, then no input → data_valid_o stays 0.
- One frame, ready_i=1: feed indices 0..1023 with spec_i=index*65537 →
  - 256 beats with data_valid_o=1.
  - First beat: y0_o=0, y0z_o=0, y1_o=1, y1z_o=1, with frame_start_o=1.
  - Last beat carries bins 510/511.
  - frame_cnt_o=1; flags 0.
- Backpressure: ready_i=0 through a full frame, then 1 → 256 back-to-back beats with bins in order, overflow_o=0. Feed a second frame while ready_i=0 → overflow_o=1 and frame 2 pairs are dropped.
- Sequence error: send index 1 first, then 2, 3 → seq_err_o=1; one beat carrying bins 2/3; frame_start_o=0.
- Reset mid-frame: assert rst_n_i after index 100 with 20 beats pending → outputs 0. The next frame from index 0 drains cleanly with frame_cnt_o=1.
- PACKER_HEADER_EN defined: two frames →
  - Header beat A55A/0000/0200/0000 precedes frame 1 data.
  - Header beat A55A/0001/0200/0000 precedes frame 2 data.
  - 257 beats per frame.
